// File: rtl/day_timer_pkg.sv
// day_timer shared constants, time-of-day struct and packing helper.
package day_timer_pkg;

  localparam int DEF_MIN_PER_HOUR = 60;
  localparam int DEF_HOUR_PER_DAY = 24;
  localparam int DEF_N_ALARM      = 4;
  localparam int DEF_MW = $clog2(DEF_MIN_PER_HOUR);
  localparam int DEF_HW = $clog2(DEF_HOUR_PER_DAY);

  typedef struct packed {
    logic [DEF_HW-1:0] hour;
    logic [DEF_MW-1:0] min;
  } tod_t;

  // Caller slices the result down to HW+MW bits.
  function automatic logic [31:0] time_pack(
    input logic [15:0] hour,
    input logic [15:0] min,
    input int          mw
  );
    return ({16'd0, hour} << mw) | {16'd0, min};
  endfunction

endpackage

// File: rtl/day_timer_prescaler.sv
// Minute-step divider: one tick per TICKS enabled cycles.
// clr restarts the count so a load re-aligns the minute boundary.
module tick_prescaler #(
  parameter int TICKS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (TICKS == 1) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, clr};
    assign tick = en;
  end else begin : g_div
    localparam int CW = $clog2(TICKS);
    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(TICKS - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (clr)
        cnt_d = '0;
      else if (en)
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/day_timer.sv
// Time-of-day counter with prescaler, checked load and
// N sticky alarm channels; all outputs registered.
module day_timer
  import day_timer_pkg::*;
#(
  parameter int TICKS_PER_MIN = 1,
  parameter int MIN_PER_HOUR  = DEF_MIN_PER_HOUR,
  parameter int HOUR_PER_DAY  = DEF_HOUR_PER_DAY,
  parameter int N_ALARM       = DEF_N_ALARM,
  localparam int MW = $clog2(MIN_PER_HOUR),
  localparam int HW = $clog2(HOUR_PER_DAY)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [HW-1:0]      load_hour,
  input  logic [MW-1:0]      load_min,
  input  logic [N_ALARM-1:0] alarm_en,
  input  logic [HW-1:0]      alarm_hour [N_ALARM],
  input  logic [MW-1:0]      alarm_min  [N_ALARM],
  input  logic [N_ALARM-1:0] alarm_ack,
  output logic [HW+MW-1:0]   time_out,
  output logic               min_tick,
  output logic               day_end,
  output logic [N_ALARM-1:0] alarm_pend,
  output logic               load_err
);

  logic [HW-1:0] hour_q, hour_d;
  logic [MW-1:0] min_q, min_d;
  logic tick_q, tick_d;
  logic day_q, day_d;
  logic err_q, err_d;
  logic [N_ALARM-1:0] pend_q, pend_d, match;
  logic load_ok, step;

  assign load_ok = (int'(load_hour) < HOUR_PER_DAY)
                && (int'(load_min) < MIN_PER_HOUR);

  // Any load, good or bad, freezes the divider for that cycle.
  tick_prescaler #(
    .TICKS (TICKS_PER_MIN)
  ) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en && !load),
    .clr   (load && load_ok),
    .tick  (step)
  );

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    tick_d = 1'b0;
    day_d  = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (load_ok) begin
        hour_d = load_hour;
        min_d  = load_min;
      end else begin
        err_d = 1'b1;
      end
    end else if (step) begin
      tick_d = 1'b1;
      if (min_q == MW'(MIN_PER_HOUR - 1)) begin
        min_d = '0;
        if (hour_q == HW'(HOUR_PER_DAY - 1)) begin
          hour_d = '0;
          day_d  = 1'b1;
        end else begin
          hour_d = hour_q + HW'(1);
        end
      end else begin
        min_d = min_q + MW'(1);
      end
    end
  end

  // hour_d/min_d are always in range, so bad alarm values never hit.
  for (genvar i = 0; i < N_ALARM; i++) begin : g_alarm
    assign match[i] = step && !load && alarm_en[i]
                   && (alarm_hour[i] == hour_d)
                   && (alarm_min[i] == min_d);
  end

  assign pend_d = (pend_q & ~alarm_ack) | match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hour_q <= '0;
      min_q  <= '0;
      tick_q <= 1'b0;
      day_q  <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
      tick_q <= tick_d;
      day_q  <= day_d;
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  assign time_out = (HW + MW)'(
    time_pack(16'(hour_q), 16'(min_q), MW));
  assign min_tick   = tick_q;
  assign day_end    = day_q;
  assign load_err   = err_q;
  assign alarm_pend = pend_q;

endmodule

// File: tb/tb_day_timer.sv
// Bench for day_timer: minutes-of-day model for two instances
// (1 and 5 ticks per minute) plus directed literal checks.
module tb_day_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  int total = 0;
  int bad = 0;

  logic en_a, load_a, en_b, load_b;
  logic [4:0] lh_a, lh_b;
  logic [5:0] lm_a, lm_b;
  logic [3:0] aen_a, ack_a, aen_b, ack_b;
  logic [4:0] ah_a [4];
  logic [5:0] am_a [4];
  logic [4:0] ah_b [4];
  logic [5:0] am_b [4];

  logic [10:0] to_a, to_b;
  logic mt_a, de_a, le_a, mt_b, de_b, le_b;
  logic [3:0] ap_a, ap_b;

  int m_t [2];
  int m_pre [2];
  logic [3:0] m_pend [2];
  logic m_mt [2];
  logic m_de [2];
  logic m_le [2];

  always #5 clk = ~clk;

  day_timer #(.TICKS_PER_MIN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a),
    .load_hour(lh_a), .load_min(lm_a), .alarm_en(aen_a),
    .alarm_hour(ah_a), .alarm_min(am_a), .alarm_ack(ack_a),
    .time_out(to_a), .min_tick(mt_a), .day_end(de_a),
    .alarm_pend(ap_a), .load_err(le_a)
  );

  day_timer #(.TICKS_PER_MIN(5)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .load(load_b),
    .load_hour(lh_b), .load_min(lm_b), .alarm_en(aen_b),
    .alarm_hour(ah_b), .alarm_min(am_b), .alarm_ack(ack_b),
    .time_out(to_b), .min_tick(mt_b), .day_end(de_b),
    .alarm_pend(ap_b), .load_err(le_b)
  );

  function automatic logic [10:0] hm(input int h, input int m);
    return {h[4:0], m[5:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic mstep(
    input int k, input int ticks, input logic en, input logic ld,
    input logic [4:0] lh, input logic [5:0] lm,
    input logic [3:0] aen, input logic [3:0] ack,
    input logic [4:0] ah [4], input logic [5:0] am [4]
  );
    bit step;
    logic [3:0] np;
    if (!rst_n) begin
      m_t[k] = 0; m_pre[k] = 0; m_pend[k] = '0;
      m_mt[k] = 0; m_de[k] = 0; m_le[k] = 0;
    end else begin
      step = 0;
      m_mt[k] = 0; m_de[k] = 0; m_le[k] = 0;
      if (ld) begin
        if (lh < 24 && lm < 60) begin
          m_t[k] = int'(lh) * 60 + int'(lm);
          m_pre[k] = 0;
        end else begin
          m_le[k] = 1;
        end
      end else if (en) begin
        m_pre[k]++;
        if (m_pre[k] == ticks) begin
          m_pre[k] = 0;
          step = 1;
        end
      end
      if (step) begin
        m_t[k] = (m_t[k] + 1) % 1440;
        m_mt[k] = 1;
        m_de[k] = (m_t[k] == 0);
      end
      np = m_pend[k] & ~ack;
      for (int i = 0; i < 4; i++)
        if (step && aen[i] && ah[i] < 24 && am[i] < 60
            && int'(ah[i]) * 60 + int'(am[i]) == m_t[k])
          np[i] = 1'b1;
      m_pend[k] = np;
    end
  endtask

  always @(posedge clk) begin
    mstep(0, 1, en_a, load_a, lh_a, lm_a, aen_a, ack_a, ah_a, am_a);
    mstep(1, 5, en_b, load_b, lh_b, lm_b, aen_b, ack_b, ah_b, am_b);
  end

  always @(negedge clk) begin
    if (run) begin
      chk("a_time", to_a, hm(m_t[0] / 60, m_t[0] % 60));
      chk("a_tick", mt_a, m_mt[0]);
      chk("a_day", de_a, m_de[0]);
      chk("a_err", le_a, m_le[0]);
      chk("a_pend", ap_a, m_pend[0]);
      chk("a_min_lt60", to_a[5:0] < 6'd60, 1);
      chk("b_time", to_b, hm(m_t[1] / 60, m_t[1] % 60));
      chk("b_tick", mt_b, m_mt[1]);
      chk("b_day", de_b, m_de[1]);
      chk("b_err", le_b, m_le[1]);
      chk("b_pend", ap_b, m_pend[1]);
    end
  end

  initial begin
    en_a = 0; load_a = 0; lh_a = 0; lm_a = 0; aen_a = 0; ack_a = 0;
    en_b = 0; load_b = 0; lh_b = 0; lm_b = 0; aen_b = 0; ack_b = 0;
    for (int i = 0; i < 4; i++) begin
      ah_a[i] = 0; am_a[i] = 0; ah_b[i] = 0; am_b[i] = 0;
    end
    repeat (2) @(negedge clk);
    run = 1;
    chk("rst_time", to_a, 0);
    chk("rst_pulses", {mt_a, de_a, le_a}, 0);
    chk("rst_pend", ap_a, 0);
    rst_n = 1;

    en_a = 1;
    repeat (60) @(negedge clk);
    en_a = 0;
    chk("t1_0100", to_a, hm(1, 0));
    chk("t1_tick", mt_a, 1);

    load_a = 1; lh_a = 23; lm_a = 58;
    @(negedge clk);
    load_a = 0;
    chk("t2_load", to_a, hm(23, 58));
    chk("t2_load_notick", mt_a, 0);
    en_a = 1;
    @(negedge clk);
    chk("t2_2359", to_a, hm(23, 59));
    chk("t2_noday", de_a, 0);
    @(negedge clk);
    en_a = 0;
    chk("t2_0000", to_a, hm(0, 0));
    chk("t2_day", de_a, 1);
    @(negedge clk);
    chk("t2_day_off", de_a, 0);

    en_b = 1;
    repeat (3) @(negedge clk);
    en_b = 0;
    repeat (10) @(negedge clk);
    chk("t3_hold", to_b, hm(0, 0));
    en_b = 1;
    repeat (2) @(negedge clk);
    en_b = 0;
    chk("t3_step", to_b, hm(0, 1));
    chk("t3_tick", mt_b, 1);
    @(negedge clk);
    chk("t3_once", to_b, hm(0, 1));

    ah_a[0] = 0; am_a[0] = 3; ah_a[1] = 0; am_a[1] = 3;
    aen_a = 4'b0001; en_a = 1;
    repeat (3) @(negedge clk);
    chk("t4_0003", to_a, hm(0, 3));
    chk("t4_pend", ap_a, 4'b0001);
    am_a[0] = 5;
    @(negedge clk);
    ack_a = 4'b0001;
    @(negedge clk);
    chk("t4_set_wins", ap_a, 4'b0001);
    @(negedge clk);
    chk("t4_acked", ap_a, 4'b0000);
    ack_a = 0; en_a = 0; aen_a = 0;

    load_a = 1; lh_a = 24; lm_a = 0;
    @(negedge clk);
    load_a = 0;
    chk("t5_err", le_a, 1);
    chk("t5_keep", to_a, hm(0, 6));
    @(negedge clk);
    chk("t5_err_off", le_a, 0);

    en_b = 1;
    repeat (4) @(negedge clk);
    load_b = 1; lh_b = 12; lm_b = 30;
    @(negedge clk);
    load_b = 0;
    chk("t5_1230", to_b, hm(12, 30));
    chk("t5_notick", mt_b, 0);
    repeat (4) @(negedge clk);
    chk("t5_wait", to_b, hm(12, 30));
    @(negedge clk);
    en_b = 0;
    chk("t5_1231", to_b, hm(12, 31));

    ah_a[0] = 5; am_a[0] = 17; aen_a = 4'b0001;
    load_a = 1; lh_a = 5; lm_a = 16;
    @(negedge clk);
    load_a = 0; en_a = 1;
    @(negedge clk);
    en_a = 0;
    chk("t6_0517", to_a, hm(5, 17));
    chk("t6_pend", ap_a, 4'b0001);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t6_time", to_a, 0);
    chk("t6_pend_clr", ap_a, 0);
    chk("t6_pulses", {mt_a, de_a, le_a}, 0);
    chk("t6_b_time", to_b, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/day_timer.md
# day_timer

Parametrised time-of-day counter for the seating controller. It is the successor to the single-rate hour/minute timer. It adds a tick prescaler, programmable minute and hour moduli, a synchronous time load, and N independent alarm channels with sticky pending flags. Downstream seat-allocation logic uses `time_out`, the one-cycle `day_end` pulse (which replaces the old level-compare `rst_timer`), and the alarm flags for scheduled events.

## Interface
Parameters:
- `TICKS_PER_MIN`, default 1: `clk` cycles per minute step; must be ≥1.
- `MIN_PER_HOUR`, default 60: minute modulus; minute counts 0..MIN_PER_HOUR-1.
- `HOUR_PER_DAY`, default 24: hour modulus; hour counts 0..HOUR_PER_DAY-1.
- `N_ALARM`, default 4: number of alarm channels, 1..16.
- Derived, not overridable: `MW = $clog2(MIN_PER_HOUR)` (6), `HW = $clog2(HOUR_PER_DAY)` (5).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: count enable; when low, the prescaler and time hold.
- `load` in 1: one-cycle request to load `load_hour:load_min`.
- `load_hour` in HW: hour value to load.
- `load_min` in MW: minute value to load.
- `alarm_en` in N_ALARM: per-channel arm.
- `alarm_hour` in N_ALARM×HW: per-channel alarm hour (unpacked array).
- `alarm_min` in N_ALARM×MW: per-channel alarm minute.
- `alarm_ack` in N_ALARM: per-channel clear of the pending flag.
- `time_out` out HW+MW: `{hour, min}`, registered.
- `min_tick` out 1: one-cycle pulse, high while a freshly advanced time is presented.
- `day_end` out 1: one-cycle pulse, high while the time is presented as 00:00 after a rollover.
- `alarm_pend` out N_ALARM: sticky per-channel alarm flags.
- `load_err` out 1: one-cycle pulse; the load was rejected as out of range.

## Operation
- Reset (`rst_n`=0 at an edge): prescaler=0, hour=0, min=0, `alarm_pend`=0, and all pulses=0. Reset overrides every other input.
- Prescaler counts 0..TICKS_PER_MIN-1 while `en`=1. When it reaches its terminal count, it wraps to 0 and issues a step.
- Step, minute: min=min+1. If min==MIN_PER_HOUR-1, min wraps to 0 and the hour steps.
- Step, hour: hour=hour+1. If hour==HOUR_PER_DAY-1, hour wraps to 0 and `day_end` fires.
- Each step sets `min_tick`. Neither counter ever presents its modulus value (for example, 60 or 24).
- Load: valid when load_hour<HOUR_PER_DAY and load_min<MIN_PER_HOUR. A valid load sets the time, clears the prescaler, and suppresses any step in that cycle. It does not fire `min_tick`, `day_end`, or alarms.
- An invalid load leaves all state unchanged and pulses `load_err`.
- `load` is honoured regardless of `en`.
- Alarm channel i: on a step, if `alarm_en[i]` is set and the post-step time equals `{alarm_hour[i], alarm_min[i]}`, `alarm_pend[i]` is set.
- `alarm_ack[i]` clears `alarm_pend[i]`. If a set and an ack for the same channel occur in the same cycle, the set wins.
- Deasserting `alarm_en[i]` does not clear a pending flag.
- Alarm values that are out of range never match.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Step latency: the edge at which the prescaler is at its terminal count updates `time_out`. `min_tick`, `day_end` and the new `alarm_pend` bits are high in that same following cycle, aligned with the new time.
- With TICKS_PER_MIN=1 and `en` held high, the time advances every cycle and `min_tick` stays high continuously.
- Load latency: the new time appears on `time_out` one cycle after `load`.
- After a load, the next step comes TICKS_PER_MIN enabled cycles later.
- Reset applied mid-count takes effect at the next edge. A pending alarm or pulse is dropped.
- Dropping `en` freezes the prescaler at its current value. Resuming continues from that value, with no lost or extra ticks.

## Structure
- Package `day_timer_pkg` holds:
  - the default constants `DEF_MIN_PER_HOUR=60`, `DEF_HOUR_PER_DAY=24`, `DEF_N_ALARM=4`;
  - a parametrisable time struct typedef `{hour, min}`;
  - a `time_pack` function producing the `{hour, min}` concatenation.
- Sub-module `tick_prescaler` (parameter TICKS, inputs `clk`, `rst_n`, `en`, `clr`, output `tick`) isolates the divider. With TICKS=1 its output is `tick`=`en`.
- The alarm compare is a generate loop over N_ALARM in the top level.

## Test plan
- Reset, then TICKS_PER_MIN=1 and `en`=1 for 60 cycles → `time_out` = 01:00. The minute sequence is 0..59 with 60 never seen. `min_tick` is high throughout.
- Load 23:58, run 2 steps → 23:59, then 00:00. `day_end` is high exactly for the 00:00 cycle only.
- TICKS_PER_MIN=5: `en` high for 3 cycles, low for 10, high for 2 → exactly one step, and `time_out` advances by 1 minute.
- Alarm 0 set to 00:03 and enabled, alarm 1 set to 00:03 and disabled; run from 00:00 → `alarm_pend`=4'b0001 starting in the 00:03 cycle. Asserting `alarm_ack[0]` in the same cycle as a later re-match leaves the bit set.
- Load 24:00 → `load_err` pulses and the time is unchanged. Load 12:30 while a step is due → `time_out`=12:30 with no `min_tick`, and the next step comes after TICKS_PER_MIN cycles.
- Assert `rst_n`=0 for one cycle at 05:17 with `alarm_pend` set → next cycle shows `time_out`=0, `alarm_pend`=0, and all pulses low.
